mc_cu: RTL

MC_CU -- requirements
Module: mc_cu

---
 rtl/mc_pkg.sv | 98 +++++++++
 rtl/mc_decode.sv | 48 ++++
 rtl/mc_cu.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: state encodings,
// opcode/function constants, ALU codes and the decoded-instruction record.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_HAMD = 6'b000001;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_LUI  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1111;
    localparam logic [3:0] ALU_HAMD = 4'b1011;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_REGA   = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    typedef struct packed {
        logic isAdd;
        logic isSub;
        logic isAnd;
        logic isOr;
        logic isXor;
        logic isSll;
        logic isSrl;
        logic isSra;
        logic isJr;
        logic isHamd;
        logic isAddi;
        logic isAndi;
        logic isOri;
        logic isXori;
        logic isLw;
        logic isSw;
        logic isBeq;
        logic isBne;
        logic isLui;
        logic isJ;
        logic isJal;
    } instr_t;

    // ALU operation implied by an instruction; address arithmetic falls back to add.
    function automatic logic [3:0] aluCode(input instr_t i);
        logic [3:0] code;
        code = ALU_ADD;
        if (i.isSub || i.isBeq || i.isBne) code = ALU_SUB;
        else if (i.isAnd || i.isAndi)      code = ALU_AND;
        else if (i.isOr  || i.isOri)       code = ALU_OR;
        else if (i.isXor || i.isXori)      code = ALU_XOR;
        else if (i.isLui)                  code = ALU_LUI;
        else if (i.isSll)                  code = ALU_SLL;
        else if (i.isSrl)                  code = ALU_SRL;
        else if (i.isSra)                  code = ALU_SRA;
        else if (i.isHamd)                 code = ALU_HAMD;
        return code;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/func to one-hot instruction
// flags, with ill raised when nothing matches.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    output instr_t     instr_o,
    output logic       ill_o
);

    always_comb begin
        instr_o = '0;
        if (op_i == OP_RTYPE) begin
            case (func_i)
                FN_ADD:  instr_o.isAdd  = 1'b1;
                FN_SUB:  instr_o.isSub  = 1'b1;
                FN_AND:  instr_o.isAnd  = 1'b1;
                FN_OR:   instr_o.isOr   = 1'b1;
                FN_XOR:  instr_o.isXor  = 1'b1;
                FN_SLL:  instr_o.isSll  = 1'b1;
                FN_SRL:  instr_o.isSrl  = 1'b1;
                FN_SRA:  instr_o.isSra  = 1'b1;
                FN_JR:   instr_o.isJr   = 1'b1;
                FN_HAMD: instr_o.isHamd = 1'b1;
                default: ;
            endcase
        end else begin
            case (op_i)
                OP_ADDI: instr_o.isAddi = 1'b1;
                OP_ANDI: instr_o.isAndi = 1'b1;
                OP_ORI:  instr_o.isOri  = 1'b1;
                OP_XORI: instr_o.isXori = 1'b1;
                OP_LUI:  instr_o.isLui  = 1'b1;
                OP_LW:   instr_o.isLw   = 1'b1;
                OP_SW:   instr_o.isSw   = 1'b1;
                OP_BEQ:  instr_o.isBeq  = 1'b1;
                OP_BNE:  instr_o.isBne  = 1'b1;
                OP_J:    instr_o.isJ    = 1'b1;
                OP_JAL:  instr_o.isJal  = 1'b1;
                default: ;
            endcase
        end
    end

    assign ill_o = (instr_o == '0);

endmodule

// File: rtl/mc_cu.sv
// Multicycle MIPS-style control unit: five-state FSM (IF/ID/EXE/MEM/WB)
// driving datapath controls from the current state and decoded instruction.
module mc_cu
    import mc_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       wmem,
    output logic       irwrite,
    output logic       pcwrite,
    output logic [1:0] pcsource,
    output logic       wreg,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       shift,
    output logic       sext,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluc,
    output logic       ill,
    output logic [2:0] state
);

    state_e state_q;
    state_e state_d;
    instr_t dec;
    logic   decIll;
    logic   rAlu;
    logic   iAlu;
    logic   branchTaken;

    mc_decode uDecode (
        .op_i    (op),
        .func_i  (func),
        .instr_o (dec),
        .ill_o   (decIll)
    );

    assign rAlu = dec.isAdd | dec.isSub | dec.isAnd | dec.isOr | dec.isXor |
                  dec.isSll | dec.isSrl | dec.isSra | dec.isHamd;
    assign iAlu = dec.isAddi | dec.isAndi | dec.isOri | dec.isXori | dec.isLui;
    assign branchTaken = (dec.isBeq & z) | (dec.isBne & ~z);

    always_ff @(posedge clock) begin
        if (!resetn) state_q <= S_IF;
        else         state_q <= state_d;
    end

    assign state = state_q;

    // Controls are decoded from the current state plus live IR/flag inputs so
    // that handshake strobes react to mem_ready in the same cycle.
    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        iord     = 1'b0;
        wmem     = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        pcsource = PCSRC_ALU;
        wreg     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        shift    = 1'b0;
        sext     = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_REGB;
        aluc     = ALU_ADD;
        ill      = 1'b0;

        case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                alusrcb = SRCB_FOUR;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                alusrcb = SRCB_BRANCH;
                sext    = 1'b1;
                state_d = S_EXE;
                if (dec.isJ) begin
                    pcwrite  = 1'b1;
                    pcsource = PCSRC_JUMP;
                    state_d  = S_IF;
                end else if (dec.isJr) begin
                    pcwrite  = 1'b1;
                    pcsource = PCSRC_REGA;
                    state_d  = S_IF;
                end else if (dec.isJal) begin
                    pcwrite  = 1'b1;
                    pcsource = PCSRC_JUMP;
                    wreg     = 1'b1;
                    jal      = 1'b1;
                    state_d  = S_IF;
                end else if (decIll) begin
                    ill     = 1'b1;
                    state_d = S_IF;
                end
            end
            S_EXE: begin
                alusrca = 1'b1;
                state_d = S_IF;
                if (dec.isLw || dec.isSw) begin
                    alusrcb = SRCB_IMM;
                    sext    = 1'b1;
                    state_d = S_MEM;
                end else if (dec.isBeq || dec.isBne) begin
                    aluc = ALU_SUB;
                    if (branchTaken) begin
                        pcwrite  = 1'b1;
                        pcsource = PCSRC_ALUOUT;
                    end
                end else if (iAlu) begin
                    alusrcb = SRCB_IMM;
                    sext    = dec.isAddi;
                    aluc    = aluCode(dec);
                    state_d = S_WB;
                end else if (rAlu) begin
                    shift   = dec.isSll | dec.isSrl | dec.isSra;
                    aluc    = aluCode(dec);
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                wmem    = dec.isSw;
                if (mem_ready) state_d = dec.isLw ? S_WB : S_IF;
            end
            S_WB: begin
                wreg    = 1'b1;
                regrt   = iAlu | dec.isLw;
                m2reg   = dec.isLw;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase

        // A reset cycle must never start an access or commit any state.
        if (!resetn) begin
            mem_req  = 1'b0;
            iord     = 1'b0;
            wmem     = 1'b0;
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            pcsource = PCSRC_ALU;
            wreg     = 1'b0;
            regrt    = 1'b0;
            m2reg    = 1'b0;
            jal      = 1'b0;
            shift    = 1'b0;
            sext     = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = SRCB_REGB;
            aluc     = ALU_ADD;
            ill      = 1'b0;
        end
    end

endmodule
